// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-4 stream demultiplexer.
package demux_pkg;

   localparam int NUM_OUT   = 4;
   localparam int SEL_W     = 2;
   localparam int DEF_WIDTH = 64;
   localparam int DEF_DEPTH = 2;

   // Ceiling log2, used to size pointers; returns 0 for values <= 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Single-clock per-channel FIFO with asynchronous active-low reset.
// The head entry is read straight from registered storage, so head_data
// has no combinational path from push/pop.
module demux_chan_fifo
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
)(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_do_push;
   logic w_do_pop;

   // Guard the storage even though the top never pushes full / pops empty.
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   assign empty     = (r_count == '0);
   assign full      = (r_count == CNT_W'(DEPTH));
   assign head_data = r_mem[r_rd_ptr];

   // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Flag any attempt to overflow or underflow the channel.
   always_ff @(posedge clock) begin
      if (reset_n) begin
         a_no_push_full: assert (!(push && full));
         a_no_pop_empty: assert (!(pop && empty));
      end
   end

endmodule

// File: rtl/demux_1to4_stream.sv
// Routes one input word stream to one of four buffered output channels.
// Handshake: a word moves across an interface on a rising edge where its
// valid and ready are both high; valid/data/sel are held by the sender until
// then, and ready never depends combinationally on the consumer's ready.
module demux_1to4_stream
   import demux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
)(
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     in_valid,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     in_ready,
   output logic [NUM_OUT-1:0]       out_valid,
   output logic [NUM_OUT*WIDTH-1:0] out_data,
   input  logic [NUM_OUT-1:0]       out_ready,
   output logic [NUM_OUT-1:0]       chan_full
);

   logic [NUM_OUT-1:0] w_push;
   logic [NUM_OUT-1:0] w_pop;
   logic [NUM_OUT-1:0] w_empty;
   logic [NUM_OUT-1:0] w_full;
   logic [WIDTH-1:0]   w_head [NUM_OUT];

   // Ready depends only on the selected channel's registered fill state.
   assign in_ready  = !w_full[in_sel];
   assign chan_full = w_full;

   // One-hot write enable for the selected channel on an accepted word.
   always_comb begin
      w_push = '0;
      if (in_valid && in_ready) begin
         w_push[in_sel] = 1'b1;
      end
   end

   for (genvar k = 0; k < NUM_OUT; k++) begin : g_chan
      assign out_valid[k]                 = !w_empty[k];
      assign w_pop[k]                     = out_valid[k] && out_ready[k];
      assign out_data[k*WIDTH +: WIDTH]   = w_head[k];

      demux_chan_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clock     (clock),
         .reset_n   (reset_n),
         .push      (w_push[k]),
         .push_data (in_data),
         .pop       (w_pop[k]),
         .head_data (w_head[k]),
         .empty     (w_empty[k]),
         .full      (w_full[k])
      );
   end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Bench for demux_1to4_stream: directed scenarios plus a random soak,
// with per-channel reference queues and a negedge monitor.
module tb_demux_1to4_stream;

  localparam int W     = 64;
  localparam int DEPTH = 2;

  logic           clock;
  logic           reset_n;
  logic           in_valid;
  logic [1:0]     in_sel;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic [3:0]     out_valid;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_ready;
  logic [3:0]     chan_full;

  logic [W-1:0] exp_q[4][$];
  int checks;
  int errors;

  demux_1to4_stream #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .chan_full (chan_full)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] head(input int k);
    return out_data[k*W +: W];
  endfunction

  // scoreboard monitor: status vs model occupancy, popped data vs queue front
  always @(negedge clock) begin
    if (reset_n) begin
      for (int k = 0; k < 4; k++) begin
        chk("out_valid_vs_model", W'(out_valid[k]), W'(exp_q[k].size() != 0));
        chk("chan_full_vs_model", W'(chan_full[k]), W'(exp_q[k].size() == DEPTH));
      end
      chk("in_ready_vs_model", W'(in_ready), W'(exp_q[in_sel].size() < DEPTH));
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            chk("unexpected_word", head(k), '1);
          end else begin
            chk("pop_data", head(k), exp_q[k].pop_front());
          end
        end
      end
      if (in_valid && in_ready) exp_q[in_sel].push_back(in_data);
    end
  end

  // driver tasks (entered and left at posedge + 1)
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic send(input logic [1:0] sel, input logic [W-1:0] data, output int stalls);
    bit done;
    done = 0;
    stalls = 0;
    in_valid = 1'b1;
    in_sel = sel;
    in_data = data;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clock);
      if (in_ready) done = 1;
      else stalls++;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  int s;
  logic [W-1:0] prev;
  bit acc;

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_sel = 2'd0;
    in_data = '0;
    out_ready = 4'hF;

    // 1: reset then route one word to channel 2
    repeat (3) begin
      @(negedge clock);
      chk("rst_out_valid", W'(out_valid), 0);
      chk("rst_chan_full", W'(chan_full), 0);
      chk("rst_in_ready", W'(in_ready), 1);
      chk("rst_out_data_hi", out_data[4*W-1 -: W], 0);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    send(2'd2, 64'hDEAD_BEEF_0000_0002, s);
    @(negedge clock);
    chk("t1_valid", W'(out_valid), W'(4'b0100));
    chk("t1_data", head(2), 64'hDEAD_BEEF_0000_0002);
    @(posedge clock); #1;
    @(negedge clock);
    chk("t1_after_pop", W'(out_valid), 0);
    @(posedge clock); #1;

    // 2: backpressure on channel 0
    out_ready = 4'b1110;
    send(2'd0, 64'hA0, s);
    send(2'd0, 64'hB0, s);
    in_valid = 1'b1;
    in_sel = 2'd0;
    in_data = 64'hC0;
    @(negedge clock);
    chk("t2_full", W'(chan_full), W'(4'b0001));
    chk("t2_ready_low", W'(in_ready), 0);
    @(posedge clock); #1;
    out_ready = 4'hF;
    @(negedge clock);
    chk("t2_no_bypass", W'(in_ready), 0);
    chk("t2_head_a", head(0), 64'hA0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("t2_ready_after_pop", W'(in_ready), 1);
    chk("t2_head_b", head(0), 64'hB0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    idle(4);
    @(negedge clock);
    chk("t2_drained", W'(out_valid), 0);
    @(posedge clock); #1;

    // 3: channel 0 stalled full, channels 1 and 3 flow freely
    out_ready = 4'b1110;
    send(2'd0, 64'h0000_0000_0000_0A01, s);
    send(2'd0, 64'h0000_0000_0000_0A02, s);
    for (int i = 0; i < 8; i++) begin
      send((i % 2) ? 2'd3 : 2'd1, {$urandom, $urandom}, s);
      chk("t3_no_stall", W'(s), 0);
    end
    idle(2);
    @(negedge clock);
    chk("t3_ch0_full", W'(chan_full), W'(4'b0001));
    chk("t3_ch0_head", head(0), 64'h0000_0000_0000_0A01);
    chk("t3_only_ch0", W'(out_valid), W'(4'b0001));
    @(posedge clock); #1;
    out_ready = 4'hF;
    idle(4);

    // 4: simultaneous push and pop on channel 1, ten cycles
    out_ready = 4'b0000;
    prev = {$urandom, $urandom};
    send(2'd1, prev, s);
    out_ready = 4'b0010;
    in_valid = 1'b1;
    in_sel = 2'd1;
    for (int i = 0; i < 10; i++) begin
      in_data = {$urandom, $urandom};
      @(negedge clock);
      chk("t4_valid", W'(out_valid), W'(4'b0010));
      chk("t4_not_full", W'(chan_full), 0);
      chk("t4_head", head(1), prev);
      prev = in_data;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    @(negedge clock);
    chk("t4_last_head", head(1), prev);
    chk("t4_last_valid", W'(out_valid), W'(4'b0010));
    @(posedge clock); #1;
    idle(2);
    @(negedge clock);
    chk("t4_drained", W'(out_valid), 0);
    @(posedge clock); #1;

    // 5: asynchronous reset between edges with every channel full
    out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      send(2'(k), {32'h5EED_0000, 32'(k)}, s);
      send(2'(k), {32'h5EED_1111, 32'(k)}, s);
    end
    chk("t5_all_full", W'(chan_full), W'(4'hF));
    #1;
    reset_n = 1'b0;
    #1;
    chk("t5_async_valid", W'(out_valid), 0);
    chk("t5_async_full", W'(chan_full), 0);
    chk("t5_async_ready", W'(in_ready), 1);
    chk("t5_async_data", out_data[W-1:0], 0);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    #1;
    reset_n = 1'b1;
    out_ready = 4'hF;
    repeat (4) begin
      @(negedge clock);
      chk("t5_no_stale", W'(out_valid), 0);
    end
    @(posedge clock); #1;

    // 6: random soak; inputs held stable while stalled
    in_valid = 1'b0;
    acc = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel = 2'($urandom_range(0, 3));
        in_data = {$urandom, $urandom};
      end
      out_ready = 4'($urandom_range(0, 15));
      @(negedge clock);
      acc = in_valid && in_ready;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    out_ready = 4'hF;
    idle(6);
    for (int k = 0; k < 4; k++) begin
      chk("soak_no_loss", W'(exp_q[k].size()), 0);
    end
    chk("soak_empty", W'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1to4_stream.md
Name: demux_1to4_stream

Overview:
- Other direction of the 64-bit 4:1 datapath selector: one input word stream is routed to one of four output channels by a 2-bit select.
- Each channel has its own small FIFO with valid/ready handshakes, so a stalled consumer blocks only its own channel.
- Sits between a result producer and four independent consumers, e.g. write-back targets.

Parameters:
- WIDTH, 64, data word width in bits.
- DEPTH, 2, entries per channel FIFO; power of two, at least 2.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_sel  input  2  destination channel 0..3; sampled with in_data.
- in_data  input  WIDTH  input word.
- in_ready  output  1  block accepts the word this cycle.
- out_valid  output  4  bit k: channel k head word is valid.
- out_data  output  4*WIDTH  channel k word is on bits [k*WIDTH +: WIDTH].
- out_ready  input  4  bit k: consumer k takes its head word this cycle.
- chan_full  output  4  bit k: channel k FIFO holds DEPTH entries.

Behaviour:
- Reset: reset_n low clears all FIFOs immediately, regardless of clock. Values while reset is held and after it releases:
  - out_valid = 0.
  - chan_full = 0.
  - in_ready = 1.
  - out_data = 0.
  - All pointers and counts = 0.
- Reset asserted mid-transfer discards every buffered word; nothing is emitted afterwards.
- Input accept: the word is accepted when in_valid && in_ready at the clock edge. in_ready = !chan_full[in_sel].
  - in_ready is a function of registered state and in_sel only. It never depends on out_ready, so there is no combinational ready path.
- An accepted word is written to the tail of FIFO[in_sel]. Exactly one channel is written per cycle.
- Output: out_valid[k] = (count[k] != 0). out_data for channel k is the head entry of FIFO k, driven from registered storage.
  - out_data for an empty channel holds its last value; consumers must not rely on it.
- Pop: a pop occurs on channel k when out_valid[k] && out_ready[k] at the clock edge. Channels pop independently; all four may pop in the same cycle.
- Latency: a word accepted at edge N shows out_valid at its channel after edge N, i.e. 1 cycle, provided the FIFO was empty.
- Ordering: words to the same channel leave in acceptance order. There is no ordering guarantee across channels.
- Simultaneous push and pop on the same channel:
  - Allowed when the channel is neither empty nor full; count stays the same and both pointers advance.
  - When the channel is full, in_ready = 0, so only the pop occurs, even though space frees that cycle (no bypass).
  - When the channel is empty, no pop is possible; only the push occurs.
- Pointers: log2(DEPTH) bits each, wrapping modulo DEPTH. count is log2(DEPTH)+1 bits with range 0..DEPTH.
  - chan_full[k] = (count[k] == DEPTH).
- in_valid low: in_sel and in_data are ignored, and no state changes on the input side.
- The input holds no data of its own. The producer must keep in_valid, in_sel and in_data stable until accepted. Changing in_sel while stalled is permitted; in_ready re-evaluates combinationally.
- No overflow or underflow is possible by construction. Simulation assertions must flag a push when full and a pop when empty.

Decomposition:
- Package demux_pkg:
  - NUM_OUT = 4 and SEL_W = 2.
  - Default WIDTH = 64 and default DEPTH = 2.
  - Function clog2 for the pointer widths.
- Sub-module demux_chan_fifo:
  - Single-clock FIFO with async active-low reset.
  - Ports: push, push_data, pop, head_data, empty, full.
  - Instantiated NUM_OUT times in a generate loop.
- Top level: select decode, in_ready mux, and out_data/out_valid packing.

Test Plan:
- Reset and route one word: assert reset_n = 0 for 3 cycles, then send in_sel = 2, in_data = 64'hDEAD_BEEF_0000_0002 with out_ready = 4'hF.
  - Required: out_valid = 0 during reset.
  - Required: out_valid = 4'b0100 one cycle after accept, with channel 2 data matching.
  - Required: out_valid = 0 the cycle after the pop.
- Backpressure on one channel: out_ready = 4'b1110, send 3 words to channel 0.
  - Required: in_ready drops after the 2nd accept and chan_full = 4'b0001.
  - Required: raising out_ready[0] pops word 1, and the 3rd word is accepted the following cycle.
- Isolation: fill channel 0 (out_ready[0] = 0), then alternate in_sel 1 and 3 with 8 words, out_ready[3:1] = 1.
  - Required: all 8 words arrive in order on channels 1 and 3 with no stall.
  - Required: channel 0 still holds its 2 words.
- Push and pop in the same cycle: channel 1 holds 1 entry; push a new word and pop the head in the same cycle.
  - Required: count stays 1; the next head is the new word; the pointers wrap correctly over 10 such cycles.
- Reset mid-operation: load 2 words into each of the 4 channels, pulse reset_n low for half a clock period between edges.
  - Required: out_valid = 0 and chan_full = 0 immediately (asynchronous).
  - Required: no stale words appear after release.
- Random soak: 10k cycles with random in_valid, in_sel and out_ready, checked against a per-channel reference queue.
  - Required: no data mismatch, loss or duplication, and no assertion fires.
